// File: rtl/envio_serial_automatico_uc.sv
// Control unit for the automatic serial dump: 8 content frames, then 16 queue frames,
// started by request or by the interval timer, with a per-frame transmit watchdog.
module envio_serial_automatico_uc #(
   parameter bit AUTO       = 1'b1,
   parameter int PERIODO    = 50000000,
   parameter int TIMEOUT_TX = 8192
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       enviado,
   input  logic       fim_transmissao_conteudo_elevador,
   input  logic       fim_transmissao_fila_elevador,
   output logic       envia_serial,
   output logic       eh_conteudo_elevador,
   output logic       conta_conteudo_elevador,
   output logic       conta_fila_elevador,
   output logic       zera_contadores,
   output logic       pronto,
   output logic       erro,
   output logic [3:0] db_estado
);

   localparam int TW = (PERIODO > 1) ? $clog2(PERIODO) : 1;
   localparam int WW = (TIMEOUT_TX > 1) ? $clog2(TIMEOUT_TX) : 1;
   localparam logic [TW-1:0] TIMER_FIM = TW'(PERIODO - 1);
   localparam logic [WW-1:0] WD_FIM    = WW'(TIMEOUT_TX - 1);

   typedef enum logic [3:0] {
      INICIAL       = 4'd0,
      ZERA          = 4'd1,
      ENVIA_CONT    = 4'd2,
      ESPERA_CONT   = 4'd3,
      PROX_CONT_FIM = 4'd4,
      ENVIA_FILA    = 4'd5,
      ESPERA_FILA   = 4'd6,
      PROX_FILA_FIM = 4'd7,
      FIM           = 4'd8,
      INC_CONT      = 4'd9,
      INC_FILA      = 4'd10,
      ERRO          = 4'd14
   } estado_t;

   estado_t       estado_q, estado_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [WW-1:0] wd_q, wd_d;
   logic          timer_fim;
   logic          wd_fim;

   assign timer_fim = AUTO && (timer_q == TIMER_FIM);
   assign wd_fim    = (wd_q == WD_FIM);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q <= INICIAL;
         timer_q  <= '0;
         wd_q     <= '0;
      end else begin
         estado_q <= estado_d;
         timer_q  <= timer_d;
         wd_q     <= wd_d;
      end
   end

   // The fim flag is sampled together with enviado, so PROX/INC is chosen on entry.
   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         INICIAL:       if (iniciar || timer_fim) estado_d = ZERA;
         ZERA:          estado_d = ENVIA_CONT;
         ENVIA_CONT:    estado_d = ESPERA_CONT;
         ESPERA_CONT: begin
            if (enviado)
               estado_d = fim_transmissao_conteudo_elevador ? PROX_CONT_FIM : INC_CONT;
            else if (wd_fim)
               estado_d = ERRO;
         end
         PROX_CONT_FIM: estado_d = ENVIA_FILA;
         INC_CONT:      estado_d = ENVIA_CONT;
         ENVIA_FILA:    estado_d = ESPERA_FILA;
         ESPERA_FILA: begin
            if (enviado)
               estado_d = fim_transmissao_fila_elevador ? PROX_FILA_FIM : INC_FILA;
            else if (wd_fim)
               estado_d = ERRO;
         end
         PROX_FILA_FIM: estado_d = FIM;
         INC_FILA:      estado_d = ENVIA_FILA;
         FIM:           estado_d = INICIAL;
         ERRO:          if (iniciar) estado_d = ZERA;
         default:       estado_d = INICIAL;
      endcase
   end

   // Interval timer only runs while idle; watchdog only runs while waiting for enviado.
   always_comb begin
      timer_d = '0;
      if (AUTO && (estado_q == INICIAL) && (estado_d == INICIAL))
         timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;

      wd_d = '0;
      if ((estado_q == ESPERA_CONT) || (estado_q == ESPERA_FILA))
         wd_d = (wd_q == '1) ? wd_q : wd_q + 1'b1;
   end

   always_comb begin
      envia_serial            = 1'b0;
      eh_conteudo_elevador    = 1'b0;
      conta_conteudo_elevador = 1'b0;
      conta_fila_elevador     = 1'b0;
      zera_contadores         = 1'b0;
      pronto                  = 1'b0;
      erro                    = 1'b0;
      case (estado_q)
         ZERA:          zera_contadores = 1'b1;
         ENVIA_CONT: begin
            envia_serial         = 1'b1;
            eh_conteudo_elevador = 1'b1;
         end
         ESPERA_CONT,
         PROX_CONT_FIM: eh_conteudo_elevador = 1'b1;
         INC_CONT: begin
            eh_conteudo_elevador    = 1'b1;
            conta_conteudo_elevador = 1'b1;
         end
         ENVIA_FILA:    envia_serial = 1'b1;
         INC_FILA:      conta_fila_elevador = 1'b1;
         FIM:           pronto = 1'b1;
         ERRO:          erro = 1'b1;
         default: ;
      endcase
   end

   assign db_estado = estado_q;

   a_estado_legal: assert property (@(posedge clock) disable iff (reset)
      estado_q inside {INICIAL, ZERA, ENVIA_CONT, ESPERA_CONT, PROX_CONT_FIM, ENVIA_FILA,
                       ESPERA_FILA, PROX_FILA_FIM, FIM, INC_CONT, INC_FILA, ERRO});

   a_pulsos_exclusivos: assert property (@(posedge clock) disable iff (reset)
      $onehot0({envia_serial, conta_conteudo_elevador, conta_fila_elevador,
                zera_contadores, pronto, erro}));

endmodule

// File: tb/tb_envio_serial_automatico_uc.sv
// Bench for envio_serial_automatico_uc: models the datapath counters and the transmitter,
// queues the expected frame sequence and checks every strobe against it.
module tb_envio_serial_automatico_uc;

   localparam int PER  = 100;
   localparam int TOUT = 50;
   localparam int DLY  = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- main DUT (AUTO=0) ----------------
   logic       iniciar   = 1'b0;
   logic       enviado_m = 1'b0;
   logic       enviado_s = 1'b0;
   logic       enviado;
   logic       fim_c, fim_f;
   logic       envia, eh, cc, cf, zera, pronto, erro;
   logic [3:0] db;
   logic [2:0] addr_c;
   logic [3:0] addr_f;

   assign enviado = enviado_m | enviado_s;
   assign fim_c   = (addr_c == 3'd7);
   assign fim_f   = (addr_f == 4'd15);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_c <= '0;
         addr_f <= '0;
      end else if (zera) begin
         addr_c <= '0;
         addr_f <= '0;
      end else begin
         if (cc) addr_c <= addr_c + 3'd1;
         if (cf) addr_f <= addr_f + 4'd1;
      end
   end

   envio_serial_automatico_uc #(.AUTO(1'b0), .PERIODO(PER), .TIMEOUT_TX(TOUT)) dut (
      .clock                             (clk),
      .reset                             (rst),
      .iniciar                           (iniciar),
      .enviado                           (enviado),
      .fim_transmissao_conteudo_elevador (fim_c),
      .fim_transmissao_fila_elevador     (fim_f),
      .envia_serial                      (envia),
      .eh_conteudo_elevador              (eh),
      .conta_conteudo_elevador           (cc),
      .conta_fila_elevador               (cf),
      .zera_contadores                   (zera),
      .pronto                            (pronto),
      .erro                              (erro),
      .db_estado                         (db)
   );

   // ---------------- second DUT (AUTO=1) for the interval timer ----------------
   logic       enviado_a = 1'b0;
   logic       fim_c_a, fim_f_a;
   logic       envia_a, eh_a, cc_a, cf_a, zera_a, pronto_a, erro_a;
   logic [3:0] db_a;
   logic [2:0] addr_c_a;
   logic [3:0] addr_f_a;
   int         tx_cnt_a = 0;

   assign fim_c_a = (addr_c_a == 3'd7);
   assign fim_f_a = (addr_f_a == 4'd15);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_c_a <= '0;
         addr_f_a <= '0;
      end else if (zera_a) begin
         addr_c_a <= '0;
         addr_f_a <= '0;
      end else begin
         if (cc_a) addr_c_a <= addr_c_a + 3'd1;
         if (cf_a) addr_f_a <= addr_f_a + 4'd1;
      end
   end

   envio_serial_automatico_uc #(.AUTO(1'b1), .PERIODO(PER), .TIMEOUT_TX(TOUT)) dut_a (
      .clock                             (clk),
      .reset                             (rst),
      .iniciar                           (1'b0),
      .enviado                           (enviado_a),
      .fim_transmissao_conteudo_elevador (fim_c_a),
      .fim_transmissao_fila_elevador     (fim_f_a),
      .envia_serial                      (envia_a),
      .eh_conteudo_elevador              (eh_a),
      .conta_conteudo_elevador           (cc_a),
      .conta_fila_elevador               (cf_a),
      .zera_contadores                   (zera_a),
      .pronto                            (pronto_a),
      .erro                              (erro_a),
      .db_estado                         (db_a)
   );

   initial begin
      forever begin
         @(negedge clk);
         enviado_a = 1'b0;
         if (rst) tx_cnt_a = 0;
         else begin
            if (tx_cnt_a != 0) begin
               tx_cnt_a--;
               if (tx_cnt_a == 0) enviado_a = 1'b1;
            end
            if (envia_a) tx_cnt_a = DLY;
         end
      end
   end

   // ---------------- transmitter model for the main DUT ----------------
   // enviado_m rises tx_dly cycles after the strobe is seen; strobe number drop_at gets no reply.
   int tx_dly  = DLY;
   int drop_at = -1;
   int tx_seen = 0;
   int tx_cnt  = 0;

   initial begin
      forever begin
         @(negedge clk);
         enviado_m = 1'b0;
         if (rst) tx_cnt = 0;
         else begin
            if (tx_cnt != 0) begin
               tx_cnt--;
               if (tx_cnt == 0) enviado_m = 1'b1;
            end
            if (envia) begin
               tx_seen++;
               if (tx_seen != drop_at) tx_cnt = tx_dly;
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame = {eh_conteudo, address of the selected counter}
   logic [4:0] exp_q[$];
   logic [4:0] cur_frame = '0;
   int n_strobe = 0, n_cc = 0, n_cf = 0, n_zera = 0, n_pronto = 0, n_erro = 0;
   int last_strobe_cyc = 0;

   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            if (envia) begin
               n_strobe++;
               last_strobe_cyc = cyc;
               cur_frame = {eh, eh ? {1'b0, addr_c} : addr_f};
               if (exp_q.size() == 0)
                  check("strobe_expected", 32'(0), 32'(1));
               else
                  check("frame", 32'(cur_frame), 32'(exp_q.pop_front()));
            end
            if (enviado_m && (db == 4'd3 || db == 4'd6))
               check("frame_stable", 32'({eh, eh ? {1'b0, addr_c} : addr_f}), 32'(cur_frame));
            if (cc)     n_cc++;
            if (cf)     n_cf++;
            if (zera)   n_zera++;
            if (pronto) n_pronto++;
            if (erro)   n_erro++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   int s_strobe, s_cc, s_cf, s_zera, s_pronto, s_erro;

   task automatic snap();
      s_strobe = n_strobe;
      s_cc     = n_cc;
      s_cf     = n_cf;
      s_zera   = n_zera;
      s_pronto = n_pronto;
      s_erro   = n_erro;
   endtask

   task automatic push_frames(input int n);
      for (int i = 0; i < n; i++) begin
         if (i < 8) exp_q.push_back({1'b1, 4'(i)});
         else       exp_q.push_back({1'b0, 4'(i - 8)});
      end
   endtask

   // iniciar sampled at edge k: zera after edge k, first strobe after edge k+1
   task automatic start_dump(input string tag);
      @(negedge clk);
      iniciar = 1'b1;
      @(negedge clk);
      iniciar = 1'b0;
      check({tag, "_zera"}, 32'(zera), 32'(1));
      check({tag, "_erro_low"}, 32'(erro), 32'(0));
      @(negedge clk);
      check({tag, "_first_strobe"}, 32'(envia), 32'(1));
   endtask

   task automatic wait_pronto(input string tag);
      int cnt = 0;
      while (!pronto && cnt < 4000) begin
         @(negedge clk);
         cnt++;
      end
      check({tag, "_pronto"}, 32'(pronto), 32'(1));
      @(negedge clk);
      check({tag, "_idle_state"}, 32'(db), 32'(0));
      check({tag, "_strobes"}, 32'(n_strobe - s_strobe), 32'(24));
      check({tag, "_conta_cont"}, 32'(n_cc - s_cc), 32'(7));
      check({tag, "_conta_fila"}, 32'(n_cf - s_cf), 32'(15));
      check({tag, "_zera_count"}, 32'(n_zera - s_zera), 32'(1));
      check({tag, "_pronto_count"}, 32'(n_pronto - s_pronto), 32'(1));
      check({tag, "_frames_left"}, 32'(exp_q.size()), 32'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   // ---------------- test sequence ----------------
   initial begin
      int cnt;
      int n;
      int tgt[6];

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_outs_main", 32'({envia, eh, cc, cf, zera, pronto, erro}), 32'(0));
      check("rst_db_main", 32'(db), 32'(0));
      check("rst_outs_auto", 32'({envia_a, eh_a, cc_a, cf_a, zera_a, pronto_a, erro_a}), 32'(0));
      check("rst_db_auto", 32'(db_a), 32'(0));
      rst = 1'b0;

      // Interval timer: PER cycles in INICIAL before ZERA, both after reset and after FIM.
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!zera_a && cnt < 1000);
      check("auto_first_zera_edges", 32'(cnt), 32'(PER));
      cnt = 0;
      n = 0;
      do begin
         @(negedge clk);
         cnt++;
         if (envia_a) n++;
      end while (!pronto_a && cnt < 3000);
      check("auto_pronto", 32'(pronto_a), 32'(1));
      check("auto_strobes", 32'(n), 32'(24));
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!zera_a && cnt < 1000);
      check("auto_period_edges", 32'(cnt), 32'(PER + 1));

      // Plain dump, transmitter replies after DLY cycles
      tx_dly = DLY;
      snap();
      push_frames(24);
      start_dump("basic");
      wait_pronto("basic");
      check("basic_no_erro", 32'(n_erro - s_erro), 32'(0));

      // enviado lands on the very edge the watchdog expires: frame must still complete
      tx_dly = TOUT;
      snap();
      push_frames(24);
      start_dump("edge");
      wait_pronto("edge");
      check("edge_no_erro", 32'(n_erro - s_erro), 32'(0));

      // No reply to the 3rd content frame: ESPERA lasts TOUT cycles, then ERRO
      tx_dly  = DLY;
      drop_at = tx_seen + 3;
      snap();
      push_frames(3);
      start_dump("err");
      cnt = 0;
      while (!erro && cnt < 2000) begin @(negedge clk); cnt++; end
      check("err_erro", 32'(erro), 32'(1));
      check("err_db", 32'(db), 32'(14));
      check("err_latency", 32'(cyc - last_strobe_cyc), 32'(TOUT + 1));
      repeat (60) @(negedge clk);
      check("err_hold", 32'(erro), 32'(1));
      check("err_strobes", 32'(n_strobe - s_strobe), 32'(3));
      check("err_frames_left", 32'(exp_q.size()), 32'(0));
      drop_at = -1;
      snap();
      push_frames(24);
      start_dump("restart");
      wait_pronto("restart");

      // Stray iniciar/enviado in non-waiting states must change nothing
      tgt = '{2, 9, 4, 5, 10, 7};
      snap();
      push_frames(24);
      start_dump("stray");
      for (int k = 0; k < 6; k++) begin
         cnt = 0;
         do begin @(negedge clk); cnt++; end while (db != 4'(tgt[k]) && cnt < 2000);
         check("stray_reach", 32'(db), 32'(tgt[k]));
         enviado_s = 1'b1;
         iniciar   = 1'b1;
         @(negedge clk);
         enviado_s = 1'b0;
         iniciar   = 1'b0;
      end
      wait_pronto("stray");
      repeat (30) @(negedge clk);
      check("stray_no_redump", 32'(n_strobe - s_strobe), 32'(24));

      // Asynchronous reset while waiting on queue frame 5
      snap();
      push_frames(24);
      start_dump("abort");
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!(db == 4'd6 && addr_f == 4'd5) && cnt < 2000);
      check("abort_reach", 32'({db, addr_f}), 32'({4'd6, 4'd5}));
      rst = 1'b1;
      #1;
      check("abort_outs", 32'({envia, eh, cc, cf, zera, pronto, erro}), 32'(0));
      check("abort_db", 32'(db), 32'(0));
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      snap();
      push_frames(24);
      start_dump("after_abort");
      wait_pronto("after_abort");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/envio_serial_automatico_uc.md
Name: envio_serial_automatico_uc

Overview:
- Control unit for the automatic serial-dump datapath (7O1 transmitter plus two address counters).
- Sequences one dump of the elevator content memory (8 entries), followed by the elevator queue memory (16 entries).
- Drives the send strobe, the content/queue mux select and the address-counter increment and clear.
- Dumps are started by an explicit request or by a periodic interval timer, and are supervised by a per-frame transmit watchdog.

Parameters:
- AUTO, 1: 1 enables periodic dumps from the interval timer; 0 means dumps are started by iniciar only.
- PERIODO, 50000000: clock cycles spent in INICIAL before an automatic dump starts.
- TIMEOUT_TX, 8192: maximum cycles to wait for enviado after a send strobe before declaring an error.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; forces INICIAL and clears all timers.
- iniciar  in  1  level or pulse request to start a dump; sampled in INICIAL and ERRO only.
- enviado  in  1  transmitter done pulse; sampled in ESPERA_* states only.
- fim_transmissao_conteudo_elevador  in  1  content address counter is at its last entry (address 7).
- fim_transmissao_fila_elevador  in  1  queue address counter is at its last entry (address 15).
- envia_serial  out  1  one-cycle start strobe to the transmitter.
- eh_conteudo_elevador  out  1  mux select: 1 selects the content frame, 0 selects the queue frame.
- conta_conteudo_elevador  out  1  one-cycle increment of the content address counter.
- conta_fila_elevador  out  1  one-cycle increment of the queue address counter.
- zera_contadores  out  1  one-cycle synchronous clear of both address counters.
- pronto  out  1  one-cycle pulse when a full dump completes.
- erro  out  1  high while in ERRO (transmit timeout).
- db_estado  out  4  current state code, for debug display.

Behaviour:
- Moore FSM; every output is decoded from the registered state only.
- On reset, and while reset is high, every output is 0 and db_estado=0.
- State codes and transitions:
  - INICIAL (0): interval timer counts when AUTO=1. Go to ZERA when iniciar=1, or when AUTO=1 and the timer reaches PERIODO-1. The timer clears on exit.
  - ZERA (1): zera_contadores=1. Next state is ENVIA_CONT.
  - ENVIA_CONT (2): envia_serial=1, eh_conteudo_elevador=1. Watchdog clears. Next state is ESPERA_CONT.
  - ESPERA_CONT (3): eh_conteudo_elevador=1; watchdog counts.
    - enviado=1 -> PROX_CONT.
    - Otherwise, watchdog reaching TIMEOUT_TX-1 -> ERRO.
  - PROX_CONT (4): eh_conteudo_elevador=1.
    - fim_conteudo=1 -> ENVIA_FILA.
    - Otherwise conta_conteudo_elevador=1 and the next state is ENVIA_CONT.
    - Decode this as the split states PROX_CONT_FIM (4) and INC_CONT (9), selected on entry using the fim value sampled in ESPERA_CONT, so that outputs stay Moore.
  - ENVIA_FILA (5), ESPERA_FILA (6), PROX_FILA_FIM (7) / INC_FILA (10): mirror the content states with eh_conteudo_elevador=0 and conta_fila_elevador.
  - FIM (8): pronto=1. Next state is INICIAL.
  - ERRO (14): erro=1. Stays here until iniciar=1, which goes to ZERA (full restart of the dump). The ERRO->ZERA restart is also valid when AUTO=0.
- Per dump, exactly 8 content frames and then 16 queue frames are sent: 24 envia_serial strobes and 22 conta pulses (7+15). zera_contadores fires once, at dump start.
- eh_conteudo_elevador and both counter addresses stay constant from each envia_serial through its enviado.
- Latency:
  - iniciar high at edge k: zera_contadores is high in cycle k+1 and the first envia_serial in cycle k+2.
  - Each frame adds 2 controller cycles (PROX + INC) beyond the transmitter time.
- Boundary conditions:
  - iniciar is ignored outside INICIAL and ERRO.
  - enviado is ignored outside ESPERA_*, including when it arrives in the same cycle as the strobe.
  - When enviado arrives on the same edge as watchdog expiry, enviado wins.
  - An asynchronous reset mid-dump aborts immediately. No counter-clear pulse is issued then; the datapath counters clear from the shared reset.
- Widths:
  - Interval timer: $clog2(PERIODO) bits.
  - Watchdog: $clog2(TIMEOUT_TX) bits.
  - Both saturate and never wrap.

Test Plan:
- AUTO=0; pulse iniciar; transmitter model returns enviado 20 cycles after each strobe -> 24 strobes, first 8 with eh_conteudo=1. Content addresses 0..7, then queue 0..15. 7 conta_conteudo and 15 conta_fila pulses. One pronto; db_estado returns to 0.
- AUTO=1, PERIODO=100, iniciar held 0 -> first zera_contadores at cycle 101 after reset release. After each pronto, the next dump starts 100 cycles later.
- TIMEOUT_TX=50, model withholds enviado on the 3rd content frame -> erro=1 and db_estado=14 after 50 cycles. No further strobes until iniciar; iniciar then restarts from address 0 with erro=0.
- Pulse iniciar and a stray enviado at several points mid-dump -> no extra strobes or counts; still exactly 24 frames.
- Assert reset during ESPERA_FILA at queue address 5 -> all outputs 0 the same cycle and db_estado=0. The next iniciar gives a complete 24-frame dump.
- enviado on the same edge as watchdog expiry -> proceeds to PROX, no erro.
